// File: rtl/instr_sequencer_pkg.sv
// Shared definitions for the instruction sequencer and the ALU it feeds:
// opcode constants, instruction word field positions and FSM encoding.
package instr_sequencer_pkg;

    localparam int IW = 12;

    localparam int OP_HI = 11;
    localparam int OP_LO = 8;
    localparam int A_HI  = 7;
    localparam int A_LO  = 4;
    localparam int B_HI  = 3;
    localparam int B_LO  = 0;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_MUL  = 4'h3;
    localparam logic [3:0] OP_AND  = 4'h4;
    localparam logic [3:0] OP_OR   = 4'h5;
    localparam logic [3:0] OP_XOR  = 4'h6;
    localparam logic [3:0] OP_DIV  = 4'h7;
    localparam logic [3:0] OP_JMP  = 4'h8;
    localparam logic [3:0] OP_HALT = 4'hF;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DECODE,
        ST_EXEC,
        ST_CAPTURE,
        ST_HALT
    } state_t;

    // Opcodes 1..7 are the ones that go through the ALU.
    function automatic logic is_alu_op(logic [3:0] op);
        return (op != OP_NOP) && !op[3];
    endfunction

endpackage

// File: rtl/instr_sequencer_if.sv
// Program ROM and ALU bus between the sequencer (master) and the
// ROM/ALU side (slave): prog_addr/prog_data, alu_op/a/b, alu_out/sinal.
interface instr_sequencer_if #(
    parameter int PC_W = 4
) ();

    logic [PC_W-1:0] prog_addr;
    logic [11:0]     prog_data;
    logic [3:0]      alu_op;
    logic [3:0]      alu_a;
    logic [3:0]      alu_b;
    logic [8:0]      alu_out;
    logic            alu_sinal;

    modport master (
        output prog_addr,
        output alu_op,
        output alu_a,
        output alu_b,
        input  prog_data,
        input  alu_out,
        input  alu_sinal
    );

    modport slave (
        input  prog_addr,
        input  alu_op,
        input  alu_a,
        input  alu_b,
        output prog_data,
        output alu_out,
        output alu_sinal
    );

endinterface

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches/decodes ROM words, drives the ALU and
// captures its registered result. Ports: clk, rst, start, bus (ROM+ALU),
// res/res_sinal/res_valid (captured result), busy, halted (status).
module instr_sequencer
    import instr_sequencer_pkg::*;
#(
    parameter int PC_W = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    instr_sequencer_if.master   bus,
    output logic [8:0]          res,
    output logic                res_sinal,
    output logic                res_valid,
    output logic                busy,
    output logic                halted
);

    state_t          state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic [IW-1:0]   ir_q, ir_d;
    logic [3:0]      alu_op_q, alu_op_d;
    logic [3:0]      alu_a_q, alu_a_d;
    logic [3:0]      alu_b_q, alu_b_d;
    logic [8:0]      res_q, res_d;
    logic            res_sinal_q, res_sinal_d;
    logic            res_valid_q, res_valid_d;

    logic [3:0] ir_op;
    logic [3:0] ir_a;
    logic [3:0] ir_b;

    assign ir_op = ir_q[OP_HI:OP_LO];
    assign ir_a  = ir_q[A_HI:A_LO];
    assign ir_b  = ir_q[B_HI:B_LO];

    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        ir_d        = ir_q;
        alu_op_d    = alu_op_q;
        alu_a_d     = alu_a_q;
        alu_b_d     = alu_b_q;
        res_d       = res_q;
        res_sinal_d = res_sinal_q;
        res_valid_d = 1'b0;

        unique case (state_q)
            ST_IDLE, ST_HALT: begin
                if (start) begin
                    pc_d    = '0;
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                ir_d    = bus.prog_data;
                pc_d    = pc_q + PC_W'(1);
                state_d = ST_DECODE;
            end
            ST_DECODE: begin
                if (is_alu_op(ir_op)) begin
                    alu_op_d = ir_op;
                    alu_a_d  = ir_a;
                    alu_b_d  = ir_b;
                    state_d  = ST_EXEC;
                end else if (ir_op == OP_JMP) begin
                    pc_d    = PC_W'(ir_a);
                    state_d = ST_FETCH;
                end else if (ir_op == OP_HALT) begin
                    state_d = ST_HALT;
                end else begin
                    state_d = ST_FETCH;
                end
            end
            ST_EXEC: begin
                // ALU samples the held inputs at the end of this cycle.
                state_d = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                res_d       = bus.alu_out;
                res_sinal_d = bus.alu_sinal;
                res_valid_d = 1'b1;
                // Park the ALU on NOP so its output returns to 0.
                alu_op_d    = OP_NOP;
                alu_a_d     = '0;
                alu_b_d     = '0;
                state_d     = ST_FETCH;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            pc_q        <= '0;
            ir_q        <= '0;
            alu_op_q    <= '0;
            alu_a_q     <= '0;
            alu_b_q     <= '0;
            res_q       <= '0;
            res_sinal_q <= 1'b0;
            res_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            ir_q        <= ir_d;
            alu_op_q    <= alu_op_d;
            alu_a_q     <= alu_a_d;
            alu_b_q     <= alu_b_d;
            res_q       <= res_d;
            res_sinal_q <= res_sinal_d;
            res_valid_q <= res_valid_d;
        end
    end

    assign bus.prog_addr = pc_q;
    assign bus.alu_op    = alu_op_q;
    assign bus.alu_a     = alu_a_q;
    assign bus.alu_b     = alu_b_q;

    assign res       = res_q;
    assign res_sinal = res_sinal_q;
    assign res_valid = res_valid_q;

    assign busy   = (state_q == ST_FETCH)  || (state_q == ST_DECODE) ||
                    (state_q == ST_EXEC)   || (state_q == ST_CAPTURE);
    assign halted = (state_q == ST_HALT);

endmodule

// File: tb/tb_instr_sequencer.sv
// Bench for instr_sequencer: behavioural ROM and ALU, plus an
// instruction-level model that predicts every cycle's outputs.
module tb_instr_sequencer;
    import instr_sequencer_pkg::*;

    localparam int LMAX = 128;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [8:0] res;
    logic       res_sinal;
    logic       res_valid;
    logic       busy;
    logic       halted;

    logic [11:0] rom [16];

    instr_sequencer_if #(.PC_W(4)) bus ();

    instr_sequencer #(.PC_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .bus       (bus),
        .res       (res),
        .res_sinal (res_sinal),
        .res_valid (res_valid),
        .busy      (busy),
        .halted    (halted)
    );

    always #5 clk = ~clk;

    function automatic logic [8:0] alu_f(logic [3:0] op, logic [3:0] a,
                                         logic [3:0] b);
        logic [8:0] x;
        logic [8:0] y;
        x = 9'(a);
        y = 9'(b);
        case (op)
            OP_ADD:  return x + y;
            OP_SUB:  return (a >= b) ? x - y : y - x;
            OP_MUL:  return x * y;
            OP_AND:  return x & y;
            OP_OR:   return x | y;
            OP_XOR:  return x ^ y;
            OP_DIV:  return (b == 0) ? 9'd0 : x / y;
            default: return 9'd0;
        endcase
    endfunction

    function automatic logic alu_s(logic [3:0] op, logic [3:0] a,
                                   logic [3:0] b);
        return (op == OP_SUB) && (a < b);
    endfunction

    assign bus.prog_data = rom[bus.prog_addr];

    always @(posedge clk) begin
        if (rst) begin
            bus.alu_out   <= '0;
            bus.alu_sinal <= 1'b0;
        end else begin
            bus.alu_out   <= alu_f(bus.alu_op, bus.alu_a, bus.alu_b);
            bus.alu_sinal <= alu_s(bus.alu_op, bus.alu_a, bus.alu_b);
        end
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input int obs, input int exp);
        n_chk++;
        if (obs == exp) n_pass++;
        else $display("FAIL %s: got %0d, want %0d", tag, obs, exp);
    endtask

    int e_busy [LMAX];
    int e_halt [LMAX];
    int e_rv   [LMAX];
    int e_res  [LMAX];
    int e_sin  [LMAX];
    int e_op   [LMAX];
    int e_a    [LMAX];
    int e_b    [LMAX];
    int e_addr [LMAX];
    int m_res = 0;
    int m_sin = 0;

    // Walks the program instruction by instruction; cycle 1 is the
    // first FETCH after the start edge.
    task automatic build(input int len);
        int c;
        int pc;
        logic [11:0] w;
        logic [3:0] op;
        logic [3:0] a;
        logic [3:0] b;
        for (int i = 0; i < LMAX; i++) begin
            e_busy[i] = 0; e_halt[i] = 0; e_rv[i] = 0;
            e_res[i] = m_res; e_sin[i] = m_sin;
            e_op[i] = 0; e_a[i] = 0; e_b[i] = 0; e_addr[i] = -1;
        end
        c = 1;
        pc = 0;
        while (c <= len) begin
            w = rom[pc];
            op = w[11:8];
            a = w[7:4];
            b = w[3:0];
            e_addr[c] = pc;
            e_busy[c] = 1;
            e_busy[c+1] = 1;
            pc = (pc + 1) % 16;
            if (op >= 1 && op <= 7) begin
                for (int k = 2; k <= 3; k++) begin
                    e_busy[c+k] = 1;
                    e_op[c+k] = int'(op);
                    e_a[c+k] = int'(a);
                    e_b[c+k] = int'(b);
                end
                e_rv[c+4] = 1;
                for (int j = c + 4; j < LMAX; j++) begin
                    e_res[j] = int'(alu_f(op, a, b));
                    e_sin[j] = int'(alu_s(op, a, b));
                end
                c += 4;
            end else if (op == 4'h8) begin
                pc = int'(a);
                c += 2;
            end else if (op == 4'hF) begin
                for (int j = c + 2; j < LMAX; j++) e_halt[j] = 1;
                break;
            end else begin
                c += 2;
            end
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_checks(input string tag);
        check({tag, ".busy"}, busy, 0);
        check({tag, ".halted"}, halted, 0);
        check({tag, ".res_valid"}, res_valid, 0);
        check({tag, ".res"}, res, 0);
        check({tag, ".res_sinal"}, res_sinal, 0);
        check({tag, ".alu_op"}, bus.alu_op, 0);
        check({tag, ".alu_a"}, bus.alu_a, 0);
        check({tag, ".alu_b"}, bus.alu_b, 0);
        check({tag, ".prog_addr"}, bus.prog_addr, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        start = 1'b0;
        step();
        rst = 1'b0;
        reset_checks("reset");
        m_res = 0;
        m_sin = 0;
    endtask

    task automatic cycle_check(input int i);
        check($sformatf("busy@%0d", i), busy, e_busy[i]);
        check($sformatf("halted@%0d", i), halted, e_halt[i]);
        check($sformatf("res_valid@%0d", i), res_valid, e_rv[i]);
        check($sformatf("res@%0d", i), res, e_res[i]);
        check($sformatf("res_sinal@%0d", i), res_sinal, e_sin[i]);
        check($sformatf("alu_op@%0d", i), bus.alu_op, e_op[i]);
        check($sformatf("alu_a@%0d", i), bus.alu_a, e_a[i]);
        check($sformatf("alu_b@%0d", i), bus.alu_b, e_b[i]);
        if (e_addr[i] >= 0)
            check($sformatf("prog_addr@%0d", i), bus.prog_addr, e_addr[i]);
    endtask

    // Start at the next edge, then compare len cycles. Start is
    // pulsed randomly while busy; rst_at > 0 resets during that cycle.
    task automatic run(input int len, input int rst_at);
        build(len);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 1; i <= len; i++) begin
            cycle_check(i);
            start = (e_busy[i] != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
            if (i == rst_at) rst = 1'b1;
            step();
            if (i == rst_at) begin
                rst = 1'b0;
                start = 1'b0;
                reset_checks("rst_mid");
                for (int k = 0; k < 3; k++) begin
                    step();
                    check("idle.busy", busy, 0);
                    check("idle.halted", halted, 0);
                    check("idle.prog_addr", bus.prog_addr, 0);
                end
                m_res = 0;
                m_sin = 0;
                return;
            end
        end
        start = 1'b0;
        m_res = e_res[len+1];
        m_sin = e_sin[len+1];
    endtask

    task automatic clear_rom();
        for (int k = 0; k < 16; k++) rom[k] = 12'h000;
    endtask

    initial begin
        clear_rom();
        do_reset();

        rom[0] = 12'h135; rom[1] = 12'hF00;
        run(12, 0);
        run(12, 0);

        do_reset();
        clear_rom();
        rom[0] = 12'h3FF; rom[1] = 12'hF00;
        run(12, 0);

        do_reset();
        clear_rom();
        rom[0] = 12'h830; rom[1] = 12'h1FF; rom[2] = 12'h1FF;
        rom[3] = 12'h534; rom[4] = 12'hF00;
        run(20, 0);

        do_reset();
        clear_rom();
        rom[0] = 12'h8E0; rom[14] = 12'h000; rom[15] = 12'h111;
        run(15, 15);

        do_reset();
        clear_rom();
        rom[0] = 12'hA12; rom[1] = 12'hF00;
        run(10, 0);

        for (int t = 0; t < 25; t++) begin
            do_reset();
            for (int k = 0; k < 16; k++) rom[k] = 12'($urandom);
            run(60, 0);
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/instr_sequencer.md
# instr_sequencer

Instruction sequencer for the 4-bit processor, sitting directly upstream of the ALU.
- Fetches 12-bit instruction words from a combinational program ROM and decodes them.
- Drives the ALU's opcode and operand inputs, waits out the ALU's one-cycle registered output, then captures the result and sign flag.
- Handles NOP, unconditional jump and HALT locally, without involving the ALU.

## Interface
Parameters:
- PC_W, 4, program counter width; program depth is 2^PC_W words.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  begins execution at address 0; sampled only in IDLE or HALT.
- prog_addr  out  PC_W  ROM address; equals the current pc.
- prog_data  in  12  ROM word, valid in the same cycle as prog_addr. Fields: [11:8] op, [7:4] a, [3:0] b.
- alu_op  out  4  ALU opcode; registered.
- alu_a  out  4  ALU operand a; registered.
- alu_b  out  4  ALU operand b; registered.
- alu_out  in  9  ALU result; registered inside the ALU.
- alu_sinal  in  1  ALU sign flag from the subtract path.
- res  out  9  last captured ALU result.
- res_sinal  out  1  sign flag captured with res.
- res_valid  out  1  one-cycle pulse when res/res_sinal update.
- busy  out  1  high in FETCH, DECODE, EXEC and CAPTURE.
- halted  out  1  high in HALT.

## Operation
- Opcodes:
  - 0000 NOP.
  - 0001 add, 0010 sub, 0011 mul, 0100 and, 0101 or, 0110 xor, 0111 div: ALU ops.
  - 1000 JMP: pc <= a field (low PC_W bits).
  - 1111 HALT.
  - 1001–1110 are undefined and execute as NOP.
- FSM states: IDLE, FETCH, DECODE, EXEC, CAPTURE, HALT.
- IDLE: on start, pc <= 0 and go to FETCH; otherwise stay.
- FETCH: ir <= prog_data; pc <= pc+1 modulo 2^PC_W (15 wraps to 0); go to DECODE.
- DECODE, by op:
  - ALU op: load alu_op/alu_a/alu_b from ir; go to EXEC.
  - NOP or undefined: go to FETCH.
  - JMP: load pc; go to FETCH.
  - HALT: go to HALT.
- EXEC: hold ALU inputs; the ALU registers its result at the end of this cycle. Go to CAPTURE.
- CAPTURE: res <= alu_out and res_sinal <= alu_sinal at the end of this cycle. Set res_valid for the next cycle; go to FETCH.
- ALU inputs return to 0 on leaving CAPTURE, so ALU output is 0 otherwise.
- HALT: start restarts at pc 0 (go to FETCH); otherwise stay.
- start is ignored while busy.
- res holds its value until the next CAPTURE; no width change (9 bits straight through).

## Timing
- Reset values:
  - state IDLE, pc 0, prog_addr 0, ir 0.
  - alu_op, alu_a, alu_b 0.
  - res 0, res_sinal 0, res_valid 0, busy 0, halted 0.
- rst in any state, mid-instruction included, applies all reset values at the next edge; no partial result is captured.
- start sampled at edge N: FETCH in cycle N+1, DECODE N+2, EXEC N+3, CAPTURE N+4.
- res_valid is high in cycle N+5, exactly one cycle, coincident with the next FETCH.
- Per-instruction cost:
  - ALU op: 4 cycles.
  - NOP, JMP, undefined: 2 cycles.
  - HALT: halted asserts 2 cycles after its FETCH.
- busy and halted are registered state decodes; they are never high together.

## Structure
- Shared package holds:
  - opcode constants OP_NOP, OP_ADD … OP_DIV, OP_JMP, OP_HALT (the ALU uses the same constants);
  - instruction field positions;
  - FSM state encoding.
- Single module; no sub-module required. The ROM is external, and the bench supplies it as a behavioural array.

## Test plan
- Program {0x135, 0xF00}: start at edge N → alu_op=0001, a=3, b=5 in cycles N+3..N+4; res=8 with res_valid in N+5; halted from N+7.
- Program {0x3FF, 0xF00} → res=225 (0x0E1), res_sinal as driven by the ALU model, a single res_valid pulse.
- Program {0x830, 0x1FF, 0x1FF, 0x534, 0xF00} → prog_addr sequence 0,1,3,4; exactly one res_valid with res=7; addresses 1's and 2's add never reaches the ALU.
- Program {0x8E0, …, addr 14 = 0x000, addr 15 = 0x111}: prog_addr runs 0,14,15,0 (wrap), with res=2 at each pass. Assert rst during the second EXEC → all outputs 0 next cycle and state IDLE.
- Program {0xA12, 0xF00} → no res_valid; alu_op stays 0000; halted asserts.
- Pulse start while busy → no effect. After HALT, pulse start → fetch restarts at address 0 and res_valid recurs.
